// File: rtl/tt_alu_pkg.sv
// Shared types for the registered ALU/accumulator tile block.
package tt_alu_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_e;

endpackage

// File: rtl/tt_sat_addsub.sv
// Combinational unsigned add/subtract with optional clamp.
// carry is the raw carry-out (add) or borrow (sub), independent of clamping.
module tt_sat_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             sat,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH:0] w_sum;

  // WIDTH+1 bit arithmetic; the top bit is carry on add and borrow on sub.
  always_comb begin
    w_sum = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    carry = w_sum[WIDTH];
    res   = w_sum[WIDTH-1:0];
    if (sat && w_sum[WIDTH]) begin
      res = sub ? '0 : '1;
    end
  end

endmodule

// File: rtl/tt_alu_accum.sv
// Registered ADD/SUB/ACC/CLR unit with valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid may not depend on ready, and the producer holds its data
// stable while valid is high and ready is low.
module tt_alu_accum
  import tt_alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);

  localparam logic LP_SAT = (SATURATE != 0);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;

  // Ready when the output slot is empty or being drained this cycle.
  assign in_ready = !rst && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // ACC adds the operand to the accumulator; ADD/SUB use a and b.
  assign w_x   = (op == OP_ACC) ? r_acc : a;
  assign w_y   = (op == OP_ACC) ? a : b;
  assign w_sub = (op == OP_SUB);

  tt_sat_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .x    (w_x),
    .y    (w_y),
    .sub  (w_sub),
    .sat  (LP_SAT),
    .res  (w_res),
    .carry(w_carry)
  );

  // Output register stage, accumulator and accepted-op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_count     <= r_count + CNT_W'(1);
        case (op)
          OP_CLR: begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
          end
          OP_ACC: begin
            r_result <= w_res;
            r_carry  <= w_carry;
            r_acc    <= w_res;
          end
          default: begin
            r_result <= w_res;
            r_carry  <= w_carry;
          end
        endcase
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign ovf       = r_carry;
  assign count     = r_count;

endmodule
